// File: rtl/silife_stepper.sv
// Generation stepper for the silife grid: Wishbone-controlled prescaler that paces o_step pulses.
// Define SILIFE_STEPPER_IRQ_EN to build the registered completion interrupt and the stored CTRL.irq_en bit.
module silife_stepper #(
   parameter int PRESCALE_BITS = 24,
   parameter int GEN_BITS      = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [23:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_ack,
   output logic [31:0] o_wb_data,
   input  logic        i_sync_busy,
   output logic        o_step,
   output logic        o_running,
   output logic        o_irq
);

   localparam logic [23:0] ADDR_CTRL   = 24'h000000;
   localparam logic [23:0] ADDR_PERIOD = 24'h000004;
   localparam logic [23:0] ADDR_COUNT  = 24'h000008;
   localparam logic [23:0] ADDR_GEN    = 24'h00000C;
   localparam logic [23:0] ADDR_STATUS = 24'h000010;

   typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD, S_STEP} state_t;

   state_t                   state, state_nxt;
   logic                     run, run_nxt, count_mode, done, single_pend;
   logic                     irq_en_rd, step_pending;
   logic [PRESCALE_BITS-1:0] period, presc;
   logic [GEN_BITS-1:0]      count, gen;
   logic [31:0]              rd_data;
   logic                     wb_req, wr, wr_ctrl, wr_period, wr_count, wr_gen, wr_status;
   logic                     step_wr, run_step, finishing;

   // A new request is only accepted while ack is low, so a held strobe gives one ack per access.
   assign wb_req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
   assign wr        = wb_req & i_wb_we;
   assign wr_ctrl   = wr & (i_wb_addr == ADDR_CTRL);
   assign wr_period = wr & (i_wb_addr == ADDR_PERIOD);
   assign wr_count  = wr & (i_wb_addr == ADDR_COUNT);
   assign wr_gen    = wr & (i_wb_addr == ADDR_GEN);
   assign wr_status = wr & (i_wb_addr == ADDR_STATUS);
   assign step_wr   = wr_ctrl & i_wb_data[1];

   // A step taken while a single step is pending is the single step; it never touches COUNT.
   assign run_step  = (state == S_STEP) & ~single_pend;
   assign finishing = run_step & count_mode & (count <= GEN_BITS'(1));

   always_comb begin
      run_nxt = run;
      if (wr_ctrl)
         run_nxt = i_wb_data[0] & ~(i_wb_data[2] & (count == '0));
      else if (finishing)
         run_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // PERIOD=0 skips COUNT entirely so step spacing stays PERIOD+2 for every PERIOD.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (step_wr | single_pend) state_nxt = S_HOLD;
            else if (run)              state_nxt = (period == '0) ? S_HOLD : S_COUNT;
         end
         S_COUNT: begin
            if (!run && !single_pend)                        state_nxt = S_IDLE;
            else if (single_pend || presc == PRESCALE_BITS'(1)) state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (!run && !single_pend) state_nxt = S_IDLE;
            else if (!i_sync_busy)    state_nxt = S_STEP;
         end
         S_STEP: begin
            if (step_wr)      state_nxt = S_HOLD;
            else if (run_nxt) state_nxt = (period == '0) ? S_HOLD : S_COUNT;
            else              state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_step       = (state == S_STEP);
      step_pending = (state == S_HOLD);
   end

   assign o_running = run;

   always_ff @(posedge clk) begin
      if (reset) begin
         run         <= 1'b0;
         count_mode  <= 1'b0;
         period      <= '0;
         presc       <= '0;
         count       <= '0;
         gen         <= '0;
         done        <= 1'b0;
         single_pend <= 1'b0;
      end else begin
         run         <= run_nxt;
         single_pend <= step_wr | (single_pend & (state != S_STEP));
         done        <= finishing | (done & ~(wr_status & i_wb_data[1]));
         if (wr_ctrl)   count_mode <= i_wb_data[2];
         if (wr_period) period     <= i_wb_data[PRESCALE_BITS-1:0];
         if (state != S_COUNT && state_nxt == S_COUNT)
            presc <= period;
         else if (state == S_COUNT && presc != '0)
            presc <= presc - PRESCALE_BITS'(1);
         if (wr_count)
            count <= i_wb_data[GEN_BITS-1:0];
         else if (run_step && count_mode && count != '0)
            count <= count - GEN_BITS'(1);
         if (wr_gen)                gen <= '0;
         else if (state == S_STEP)  gen <= gen + GEN_BITS'(1);
      end
   end

`ifdef SILIFE_STEPPER_IRQ_EN
   logic irq_en;
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en <= 1'b0;
         o_irq  <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= i_wb_data[3];
         o_irq <= done & irq_en;
      end
   end
   assign irq_en_rd = irq_en;
`else
   assign irq_en_rd = 1'b0;
   assign o_irq     = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (i_wb_addr)
         ADDR_CTRL: begin
            rd_data[0] = run;
            rd_data[2] = count_mode;
            rd_data[3] = irq_en_rd;
         end
         ADDR_PERIOD: rd_data[PRESCALE_BITS-1:0] = period;
         ADDR_COUNT:  rd_data[GEN_BITS-1:0]      = count;
         ADDR_GEN:    rd_data[GEN_BITS-1:0]      = gen;
         ADDR_STATUS: rd_data[2:0]               = {step_pending, done, run};
         default:     rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= '0;
      end else begin
         o_wb_ack  <= wb_req;
         o_wb_data <= wb_req ? rd_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_silife_stepper.sv
// Directed bench for silife_stepper: register access, run pacing, count mode, sync hold-off, reset.
module tb_silife_stepper;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
   logic [23:0] i_wb_addr = '0;
   logic [31:0] i_wb_data = '0;
   logic        o_wb_ack;
   logic [31:0] o_wb_data;
   logic        i_sync_busy = 1'b0;
   logic        o_step, o_running, o_irq;

   int total = 0;
   int bad = 0;
   int cyc_n = 0;
   int step_cnt = 0;
   int last_step_cyc = 0;
   int last_gap = 0;

   silife_stepper dut (
      .clk(clk), .reset(reset),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
      .i_sync_busy(i_sync_busy), .o_step(o_step),
      .o_running(o_running), .o_irq(o_irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   always @(negedge clk) begin
      if (o_step) begin
         step_cnt      = step_cnt + 1;
         last_gap      = cyc_n - last_step_cyc;
         last_step_cyc = cyc_n;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wb_write(input logic [23:0] a, input logic [31:0] d);
      @(negedge clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
      @(posedge clk);
      @(negedge clk);
      chk("wr_ack", {31'b0, o_wb_ack}, 32'h1);
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic [23:0] a, output logic [31:0] d);
      @(negedge clk);
      i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = a;
      @(posedge clk);
      @(negedge clk);
      d = o_wb_data;
      i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [23:0] a, input logic [31:0] exp);
      logic [31:0] d;
      wb_read(a, d);
      chk(tag, d, exp);
   endtask

   task automatic wait_steps(input int target, input int budget);
      int n = 0;
      while (step_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (step_cnt < target) chk("step_timeout", step_cnt, target);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int base, drop_cyc;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // reset state
      chk("rst_ack", {31'b0, o_wb_ack}, 32'h0);
      chk("rst_data", o_wb_data, 32'h0);
      chk("rst_step", {31'b0, o_step}, 32'h0);
      chk("rst_irq", {31'b0, o_irq}, 32'h0);
      rd_chk("rst_ctrl", 24'h00, 32'h0);
      rd_chk("rst_period", 24'h04, 32'h0);
      rd_chk("rst_count", 24'h08, 32'h0);
      rd_chk("rst_gen", 24'h0C, 32'h0);
      rd_chk("rst_status", 24'h10, 32'h0);

      // unmapped addresses ack, read 0, store nothing
      wb_write(24'h000020, 32'hFFFF_FFFF);
      rd_chk("unmapped_rd", 24'h20, 32'h0);
      rd_chk("unmapped_ctrl", 24'h00, 32'h0);
      wb_write(24'h08, 32'h1234_5678);
      rd_chk("count_rw", 24'h08, 32'h1234_5678);
      wb_write(24'h08, 32'h0);

      // free run, PERIOD=3: pulses 5 cycles apart, GEN=4 after 4 pulses
      base = step_cnt;
      wb_write(24'h04, 32'd3);
      wb_write(24'h00, 32'h1);
      chk("running", {31'b0, o_running}, 32'h1);
      wait_steps(base + 1, 40);
      for (int k = 2; k <= 4; k++) begin
         wait_steps(base + k, 40);
         chk("gap_p3", last_gap, 5);
      end
      wb_write(24'h00, 32'h0);
      idle(12);
      chk("abort_count", step_cnt - base, 4);
      rd_chk("gen4", 24'h0C, 32'd4);
      chk("stopped", {31'b0, o_running}, 32'h0);

      // count mode: PERIOD=0, COUNT=3 -> three pulses two cycles apart, then done
      wb_write(24'h0C, 32'h0);
      rd_chk("gen_clear", 24'h0C, 32'h0);
      base = step_cnt;
      wb_write(24'h04, 32'd0);
      wb_write(24'h08, 32'd3);
      wb_write(24'h00, 32'h5);
      wait_steps(base + 2, 40);
      chk("gap_p0", last_gap, 2);
      idle(15);
      chk("cm_steps", step_cnt - base, 3);
      rd_chk("cm_ctrl", 24'h00, 32'h4);
      rd_chk("cm_status", 24'h10, 32'h2);
      rd_chk("cm_count", 24'h08, 32'h0);
      rd_chk("cm_gen", 24'h0C, 32'd3);

      // run=1 with count_mode and COUNT=0 is refused; done untouched
      wb_write(24'h00, 32'h5);
      idle(5);
      rd_chk("refuse_ctrl", 24'h00, 32'h4);
      rd_chk("refuse_status", 24'h10, 32'h2);
      chk("refuse_steps", step_cnt - base, 3);
      wb_write(24'h10, 32'h2);
      rd_chk("done_w1c", 24'h10, 32'h0);

      // single steps bump GEN, never COUNT, and step reads back 0
      base = step_cnt;
      wb_write(24'h08, 32'd7);
      wb_write(24'h00, 32'h2);
      idle(8);
      chk("single_steps", step_cnt - base, 1);
      rd_chk("single_gen", 24'h0C, 32'd4);
      rd_chk("single_count", 24'h08, 32'd7);
      rd_chk("single_ctrl", 24'h00, 32'h0);
      wb_write(24'h00, 32'h6);
      idle(8);
      chk("single_cm_steps", step_cnt - base, 2);
      rd_chk("single_cm_count", 24'h08, 32'd7);
      rd_chk("single_cm_ctrl", 24'h00, 32'h4);

      // sync busy holds the step off; pulse lands one cycle after busy falls
      base = step_cnt;
      wb_write(24'h04, 32'd3);
      @(negedge clk) i_sync_busy = 1'b1;
      wb_write(24'h00, 32'h1);
      idle(10);
      chk("busy_nostep", step_cnt - base, 0);
      rd_chk("busy_status", 24'h10, 32'h5);
      @(negedge clk);
      i_sync_busy = 1'b0;
      drop_cyc = cyc_n;
      wait_steps(base + 1, 20);
      chk("busy_delay", last_step_cyc - drop_cyc, 1);
      @(negedge clk) i_sync_busy = 1'b1;
      idle(10);
      chk("busy_single", step_cnt - base, 1);
      wb_write(24'h00, 32'h0);
      idle(3);
      i_sync_busy = 1'b0;
      idle(10);
      chk("hold_abort", step_cnt - base, 1);
      rd_chk("hold_abort_status", 24'h10, 32'h0);

      // completion interrupt
      wb_write(24'h04, 32'd0);
      wb_write(24'h08, 32'd1);
      wb_write(24'h00, 32'hD);
      idle(8);
      rd_chk("irq_status", 24'h10, 32'h2);
`ifdef SILIFE_STEPPER_IRQ_EN
      chk("irq_rise", {31'b0, o_irq}, 32'h1);
      rd_chk("irq_ctrl", 24'h00, 32'hC);
      wb_write(24'h10, 32'h2);
      idle(2);
      chk("irq_fall", {31'b0, o_irq}, 32'h0);
`else
      chk("irq_tied", {31'b0, o_irq}, 32'h0);
      rd_chk("irq_ctrl", 24'h00, 32'h4);
      wb_write(24'h10, 32'h2);
      idle(2);
      chk("irq_tied2", {31'b0, o_irq}, 32'h0);
`endif

      // reset while parked in HOLD drops the step
      base = step_cnt;
      wb_write(24'h00, 32'h0);
      @(negedge clk) i_sync_busy = 1'b1;
      wb_write(24'h00, 32'h1);
      idle(5);
      rd_chk("pre_rst_status", 24'h10, 32'h5);
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      i_sync_busy = 1'b0;
      reset = 1'b0;
      idle(10);
      chk("rst_hold_steps", step_cnt - base, 0);
      rd_chk("rst2_ctrl", 24'h00, 32'h0);
      rd_chk("rst2_period", 24'h04, 32'h0);
      rd_chk("rst2_count", 24'h08, 32'h0);
      rd_chk("rst2_gen", 24'h0C, 32'h0);
      rd_chk("rst2_status", 24'h10, 32'h0);
      chk("rst2_irq", {31'b0, o_irq}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/silife_stepper.md
SILIFE_STEPPER -- requirements
Module: silife_stepper

Interface
REQ-001 SHALL have parameter PRESCALE_BITS, default 24, width of the step-period prescaler.
REQ-002 SHALL have parameter GEN_BITS, default 32 (max 32), width of the generation and countdown counters.
REQ-003 SHALL have port clk, input, 1, system clock; reset is synchronous, active-high, named reset, on clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have Wishbone slave ports i_wb_cyc/i_wb_stb/i_wb_we (1 each), i_wb_addr (24), i_wb_data (32), output o_wb_ack (1) and o_wb_data (32).
REQ-006 SHALL have port i_sync_busy, input, 1, inter-grid sync in progress; holds off steps.
REQ-007 SHALL have port o_step, output, 1, one-cycle generation-advance pulse to the grid enable.
REQ-008 SHALL have port o_running, output, 1, equals the CTRL.run bit.
REQ-009 SHALL have port o_irq, output, 1, completion interrupt (see Configuration).

Function
REQ-010 Registers SHALL be: 0x00 CTRL (b0 run, b1 step, b2 count_mode, b3 irq_en); 0x04 PERIOD (PRESCALE_BITS, cycles between steps minus 1); 0x08 COUNT (GEN_BITS remaining); 0x0C GEN (GEN_BITS total, read-only, any write clears it); 0x10 STATUS (b0 running, b1 done, b2 step_pending).
REQ-011 o_wb_ack SHALL assert exactly one cycle after cyc&stb is sampled while ack is low, for one cycle; reads/writes to unmapped addresses ack, read 0, write nothing.
REQ-012 o_wb_data SHALL be registered with the ack; unused bits read 0; CTRL.step always reads 0.
REQ-013 FSM SHALL have states IDLE, COUNT, HOLD, STEP.
REQ-014 IDLE: run rising or step write SHALL load prescaler with PERIOD and enter COUNT (step write enters HOLD directly).
REQ-015 COUNT: prescaler SHALL decrement each cycle; at 0 enter HOLD.
REQ-016 HOLD: SHALL enter STEP on the first cycle i_sync_busy is low; STATUS.step_pending=1 while in HOLD.
REQ-017 STEP: o_step SHALL be high exactly this one cycle; GEN increments (wraps to 0 at all-ones); then COUNT (prescaler reloaded) if run, else IDLE.
REQ-018 With count_mode=1 a run-generated step SHALL decrement COUNT; when COUNT reaches 0, run clears and STATUS.done sets in the same cycle.
REQ-019 Single steps SHALL increment GEN but never decrement COUNT.
REQ-020 Writing run=1 with count_mode=1 and COUNT=0 SHALL leave run=0 and done unchanged.
REQ-021 Clearing run in COUNT or HOLD SHALL abort the pending run step and return to IDLE next cycle, unless a single step is pending.
REQ-022 PERIOD writes while running SHALL take effect at the next prescaler reload.
REQ-023 STATUS.done SHALL be cleared by writing 1 to STATUS b1 (W1C); a set and clear in the same cycle leaves done=1.
REQ-024 Minimum step spacing SHALL be PERIOD+2 cycles with i_sync_busy low.

Reset
REQ-025 reset SHALL set state IDLE, CTRL=0, PERIOD=0, COUNT=0, GEN=0, done=0, prescaler=0, o_step=0, o_irq=0, o_wb_ack=0, o_wb_data=0.
REQ-026 reset mid-operation SHALL drop any pending step without emitting o_step.

Configuration
REQ-027 Macro SILIFE_STEPPER_IRQ_EN defined: o_irq = STATUS.done & CTRL.irq_en, registered.
REQ-028 Macro undefined: o_irq tied 0, CTRL.irq_en not stored and reads 0.

Verification
REQ-029 PERIOD=3, CTRL=0x1 -> o_step pulses every 5 cycles; GEN reads 4 after 4 pulses.
REQ-030 PERIOD=0, COUNT=3, CTRL=0x5 -> exactly 3 o_step pulses, then run=0, STATUS=0x2, COUNT=0.
REQ-031 i_sync_busy high 10 cycles when prescaler expires -> STATUS.step_pending=1, o_step delayed to first cycle after busy falls, single pulse.
REQ-032 CTRL=0x2 with run=0 -> one o_step, GEN+1, COUNT unchanged, CTRL reads 0x0.
REQ-033 IRQ build, COUNT=1, CTRL=0xD -> o_irq rises after the step; write STATUS=0x2 -> o_irq falls; non-IRQ build o_irq stays 0.
REQ-034 reset asserted in HOLD -> no o_step, all registers read reset values.
